// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared types and sizing helpers for the keypad matrix scanner.
// Includes the FSM state and scan-result enums and the code-width function.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } scan_res_t;

  function automatic int code_width(input int rows, input int cols);
    return (rows * cols < 2) ? 1 : $clog2(rows * cols);
  endfunction

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Key-code queue handshake between the scanner (master) and the game logic (slave).
interface keypad_if #(
  parameter int CW = 4
) ();
  logic [CW-1:0] key_code;
  logic          key_valid;
  logic          key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_matrix_scanner_fifo.sv
// First-word fall-through key-code FIFO; occupancy uses one extra pointer bit.
// A push while full with no same-cycle pop is dropped and flagged on drop.
module key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop_ok_s, push_ok_s;

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign drop      = push && !push_ok_s;
  assign dout      = mem_q[rd_q[AW-1:0]];

  // Next-state pointers and storage.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok_s) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d                = wr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_d = wr_q;
    end
    if (pop_ok_s) begin
      rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_d = rd_q;
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= {(AW + 1){1'b0}};
      rd_q <= {(AW + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: one-cold column strobe, synchronised row sampling,
// per-scan debounce FSM with multi-key rejection and auto-repeat, queued key codes.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS     = 4,
  parameter int NUM_COLS     = 4,
  parameter int SCAN_DIV     = 4,
  parameter int STABLE_SCANS = 2,
  parameter int HOLD_REPEAT  = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  keypad_if.master            kbus,
  output logic                key_pressed,
  output logic                multi_err,
  output logic                overflow
);

  localparam int CW = code_width(NUM_ROWS, NUM_COLS);
  localparam int DW = cnt_width(SCAN_DIV - 1);
  localparam int IW = cnt_width(NUM_COLS - 1);
  localparam int SW = cnt_width(STABLE_SCANS) + 1;
  localparam int RW = cnt_width(HOLD_REPEAT) + 1;
  localparam logic [NUM_COLS-1:0] COL_ONE = {{(NUM_COLS - 1){1'b0}}, 1'b1};

  logic [DW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NUM_COLS-1:0] col_q, col_d;
  logic [NUM_ROWS-1:0] sync1_q, sync2_q;
  logic [1:0]          hit_cnt_q, hit_cnt_d;
  logic [CW-1:0]       hit_code_q, hit_code_d;
  scan_state_t         state_q, state_d;
  logic [CW-1:0]       cand_q, cand_d;
  logic [SW-1:0]       cnt_q, cnt_d;
  logic [RW-1:0]       rep_q, rep_d;
  logic                key_pressed_q, key_pressed_d;
  logic                multi_err_q, multi_err_d;
  logic                overflow_q, overflow_d;

  logic                last_dwell_s, scan_end_s, push_s;
  logic [1:0]          col_hits_s, tot_hits_s;
  logic [CW-1:0]       col_code_s, tot_code_s, fifo_dout_s;
  scan_res_t           res_s;
  logic                fifo_full_s, fifo_empty_s, fifo_drop_s;

  assign col            = col_q;
  assign key_pressed    = key_pressed_q;
  assign multi_err      = multi_err_q;
  assign overflow       = overflow_q;
  assign kbus.key_code  = fifo_dout_s;
  assign kbus.key_valid = ~fifo_empty_s;

  // Dwell/column counters and the accumulated per-scan hit summary.
  always_comb begin
    last_dwell_s = (div_q == DW'(SCAN_DIV - 1));
    scan_end_s   = last_dwell_s && (idx_q == IW'(NUM_COLS - 1));
    div_d        = last_dwell_s ? {DW{1'b0}} : div_q + {{(DW - 1){1'b0}}, 1'b1};
    if (scan_end_s) begin
      idx_d = {IW{1'b0}};
    end else if (last_dwell_s) begin
      idx_d = idx_q + {{(IW - 1){1'b0}}, 1'b1};
    end else begin
      idx_d = idx_q;
    end
    col_d = ~(COL_ONE << idx_d);

    col_hits_s = 2'd0;
    col_code_s = {CW{1'b0}};
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!sync2_q[r] && (col_hits_s == 2'd0)) begin
        col_code_s = CW'(r * NUM_COLS + int'(idx_q));
        col_hits_s = 2'd1;
      end else if (!sync2_q[r]) begin
        col_hits_s = 2'd2;
      end else begin
        col_hits_s = col_hits_s;
      end
    end

    // Hit count saturates at two: anything beyond one key is simply "multi".
    if (hit_cnt_q == 2'd0) begin
      tot_hits_s = col_hits_s;
    end else if (col_hits_s == 2'd0) begin
      tot_hits_s = hit_cnt_q;
    end else begin
      tot_hits_s = 2'd2;
    end
    tot_code_s = (hit_cnt_q == 2'd0) ? col_code_s : hit_code_q;

    case (tot_hits_s)
      2'd0:    res_s = NONE;
      2'd1:    res_s = SINGLE;
      default: res_s = MULTI;
    endcase

    if (scan_end_s) begin
      hit_cnt_d  = 2'd0;
      hit_code_d = {CW{1'b0}};
    end else if (last_dwell_s) begin
      hit_cnt_d  = tot_hits_s;
      hit_code_d = tot_code_s;
    end else begin
      hit_cnt_d  = hit_cnt_q;
      hit_code_d = hit_code_q;
    end
  end

  // Debounce / hold / release FSM, evaluated once per completed scan.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    push_s  = 1'b0;
    if (scan_end_s) begin
      case (state_q)
        IDLE: begin
          if (res_s == SINGLE) begin
            cand_d = tot_code_s;
            cnt_d  = SW'(1);
            rep_d  = {RW{1'b0}};
            if (STABLE_SCANS == 1) begin
              push_s  = 1'b1;
              state_d = PRESSED;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            cnt_d = {SW{1'b0}};
          end
        end
        DEBOUNCE: begin
          if ((res_s == SINGLE) && (tot_code_s == cand_q)) begin
            if (int'(cnt_q) + 1 >= STABLE_SCANS) begin
              push_s  = 1'b1;
              state_d = PRESSED;
              cnt_d   = {SW{1'b0}};
              rep_d   = {RW{1'b0}};
            end else begin
              cnt_d = cnt_q + SW'(1);
            end
          end else begin
            state_d = IDLE;
            cnt_d   = {SW{1'b0}};
          end
        end
        PRESSED: begin
          if ((res_s == SINGLE) && (tot_code_s == cand_q)) begin
            if (HOLD_REPEAT == 0) begin
              rep_d = {RW{1'b0}};
            end else if (int'(rep_q) + 1 >= HOLD_REPEAT) begin
              push_s = 1'b1;
              rep_d  = {RW{1'b0}};
            end else begin
              rep_d = rep_q + RW'(1);
            end
          end else begin
            state_d = RELEASE;
            cnt_d   = SW'(1);
            rep_d   = {RW{1'b0}};
          end
        end
        RELEASE: begin
          if (res_s == NONE) begin
            if (int'(cnt_q) + 1 >= STABLE_SCANS) begin
              state_d = IDLE;
              cnt_d   = {SW{1'b0}};
            end else begin
              cnt_d = cnt_q + SW'(1);
            end
          end else if ((res_s == SINGLE) && (tot_code_s == cand_q)) begin
            state_d = PRESSED;
            cnt_d   = {SW{1'b0}};
            rep_d   = {RW{1'b0}};
          end else begin
            cnt_d = SW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = {SW{1'b0}};
          rep_d   = {RW{1'b0}};
        end
      endcase
    end else begin
      push_s = 1'b0;
    end
    key_pressed_d = (state_d == PRESSED) || (state_d == RELEASE);
    multi_err_d   = scan_end_s && (res_s == MULTI);
    overflow_d    = fifo_drop_s && fifo_full_s;
  end

  // Scanner, synchroniser and FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= {DW{1'b0}};
      idx_q         <= {IW{1'b0}};
      col_q         <= ~COL_ONE;
      sync1_q       <= {NUM_ROWS{1'b1}};
      sync2_q       <= {NUM_ROWS{1'b1}};
      hit_cnt_q     <= 2'd0;
      hit_code_q    <= {CW{1'b0}};
      state_q       <= IDLE;
      cand_q        <= {CW{1'b0}};
      cnt_q         <= {SW{1'b0}};
      rep_q         <= {RW{1'b0}};
      key_pressed_q <= 1'b0;
      multi_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      div_q         <= div_d;
      idx_q         <= idx_d;
      col_q         <= col_d;
      sync1_q       <= row;
      sync2_q       <= sync1_q;
      hit_cnt_q     <= hit_cnt_d;
      hit_code_q    <= hit_code_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      rep_q         <= rep_d;
      key_pressed_q <= key_pressed_d;
      multi_err_q   <= multi_err_d;
      overflow_q    <= overflow_d;
    end
  end

  key_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (cand_d),
    .pop   (kbus.key_ready),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .drop  (fifo_drop_s)
  );

endmodule
